// File: rtl/nic8_trace_pkg.sv
// Shared types and rd_data field offsets for the nic8 trace monitor.
// Offsets assume the default 8-bit fields and 14 control bits.
package nic8_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP    = 2'd0,
        PCMATCH = 2'd1,
        QCHANGE = 2'd2,
        EXT     = 2'd3
    } mode_t;

    localparam int DW_DEF    = 8;
    localparam int CTRLW_DEF = 14;

    localparam int OFF_CTRL = 0;
    localparam int OFF_DBUS = CTRLW_DEF;
    localparam int OFF_ABUS = OFF_DBUS + DW_DEF;
    localparam int OFF_QREG = OFF_ABUS + DW_DEF;
    localparam int OFF_XREG = OFF_QREG + DW_DEF;
    localparam int OFF_BREG = OFF_XREG + DW_DEF;
    localparam int OFF_AREG = OFF_BREG + DW_DEF;
    localparam int OFF_IR   = OFF_AREG + DW_DEF;
    localparam int OFF_PC   = OFF_IR + DW_DEF;

endpackage

// File: rtl/trace_ram.sv
// Snapshot store: one write port, one registered read port.
// Only the read register is reset; the array is not.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 78,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/trace_monitor.sv
// Circular snapshot capture of CPU state with selectable trigger,
// post-trigger tail and oldest-first valid/ready readout.
module trace_monitor
    import nic8_trace_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CTRLW = 14,
    parameter int DEPTH = 16,
    localparam int SNAPW = 8*DW+CTRLW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arm,
    input  logic [1:0]       mode,
    input  logic [31:0]      step_limit,
    input  logic [DW-1:0]    match_pc,
    input  logic [AW-1:0]    post_count,
    input  logic             trig_in,
    input  logic [DW-1:0]    pc,
    input  logic [DW-1:0]    ir,
    input  logic [DW-1:0]    areg,
    input  logic [DW-1:0]    breg,
    input  logic [DW-1:0]    xreg,
    input  logic [DW-1:0]    qreg,
    input  logic [DW-1:0]    abus,
    input  logic [DW-1:0]    dbus,
    input  logic [CTRLW-1:0] ctrl,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [SNAPW-1:0] rd_data,
    output logic             rd_last,
    output logic [1:0]       state,
    output logic             triggered,
    output logic [31:0]      ticks
);

    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_F    = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P    = AW'(1);

    state_t          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic [31:0]     step_q, step_d;
    logic [DW-1:0]   mpc_q, mpc_d;
    logic [DW-1:0]   prevq_q, prevq_d;
    logic [AW-1:0]   pcnt_q, pcnt_d;
    logic [AW-1:0]   post_left_q, post_left_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [AW:0]     rd_cnt_q, rd_cnt_d;
    logic [31:0]     ticks_q, ticks_d;
    logic            first_q, first_d;
    logic            trig_q, trig_d;
    logic            fetch_q, fetch_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic            arm_ok, hs, fire, we;
    logic [SNAPW-1:0] snap;

    assign snap   = {pc, ir, areg, breg, xreg, qreg, abus, dbus, ctrl};
    assign arm_ok = arm && (state_q == IDLE || state_q == DRAIN);
    assign hs     = state_q == DRAIN && rd_valid_q && rd_ready;
    assign we     = state_q == ARMED || state_q == POST;

    always_comb begin
        fire = 1'b0;
        unique case (mode_q)
            STEP:    fire = ticks_q == step_q;
            PCMATCH: fire = pc == mpc_q;
            QCHANGE: fire = !first_q && qreg != prevq_q;
            EXT:     fire = trig_in;
            default: fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (arm) state_d = ARMED;
            ARMED: if (fire) state_d = (pcnt_q == '0) ? DRAIN : POST;
            POST:  if (post_left_q == ONE_P) state_d = DRAIN;
            DRAIN: begin
                if (arm)                  state_d = ARMED;
                else if (hs && rd_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        step_d      = step_q;
        mpc_d       = mpc_q;
        pcnt_d      = pcnt_q;
        prevq_d     = prevq_q;
        post_left_d = post_left_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        rd_cnt_d    = rd_cnt_q;
        ticks_d     = ticks_q;
        first_d     = first_q;
        trig_d      = trig_q;
        fetch_d     = fetch_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;

        if (state_q != IDLE && ticks_q != '1) ticks_d = ticks_q + 32'd1;

        if (we) begin
            wr_ptr_d = wr_ptr_q + ONE_P;
            if (fill_q != FULL) fill_d = fill_q + ONE_F;
        end

        if (state_q == ARMED) begin
            prevq_d = qreg;
            first_d = 1'b0;
            if (fire) begin
                trig_d      = 1'b1;
                post_left_d = pcnt_q;
            end
        end

        if (state_q == POST) post_left_d = post_left_q - ONE_P;

        // Oldest entry is slot 0 until the ring has wrapped once.
        if (state_d == DRAIN && state_q != DRAIN) begin
            rd_ptr_d = (fill_d < FULL) ? '0 : wr_ptr_d;
            rd_cnt_d = '0;
            fetch_d  = 1'b1;
        end

        if (state_q == DRAIN) begin
            if (fetch_q) begin
                fetch_d    = 1'b0;
                rd_valid_d = 1'b1;
                rd_last_d  = rd_cnt_q == fill_q - ONE_F;
            end
            if (hs) begin
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
                rd_ptr_d   = rd_ptr_q + ONE_P;
                rd_cnt_d   = rd_cnt_q + ONE_F;
                fetch_d    = !rd_last_q;
            end
        end

        if (arm_ok) begin
            mode_d     = mode_t'(mode);
            step_d     = step_limit;
            mpc_d      = match_pc;
            pcnt_d     = post_count;
            wr_ptr_d   = '0;
            fill_d     = '0;
            ticks_d    = '0;
            trig_d     = 1'b0;
            first_d    = 1'b1;
            fetch_d    = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= STEP;
            step_q      <= '0;
            mpc_q       <= '0;
            pcnt_q      <= '0;
            prevq_q     <= '0;
            post_left_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            rd_cnt_q    <= '0;
            ticks_q     <= '0;
            first_q     <= 1'b0;
            trig_q      <= 1'b0;
            fetch_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            step_q      <= step_d;
            mpc_q       <= mpc_d;
            pcnt_q      <= pcnt_d;
            prevq_q     <= prevq_d;
            post_left_q <= post_left_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            rd_cnt_q    <= rd_cnt_d;
            ticks_q     <= ticks_d;
            first_q     <= first_d;
            trig_q      <= trig_d;
            fetch_q     <= fetch_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (SNAPW)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (snap),
        .re    (fetch_q),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        state     = state_q;
        rd_valid  = rd_valid_q;
        rd_last   = rd_last_q;
        triggered = trig_q;
        ticks     = ticks_q;
    end

endmodule

// File: tb/tb_trace_monitor.sv
// Scoreboard bench for trace_monitor: every driven snapshot is queued,
// the queue keeps the newest DEPTH entries, and drains are popped against it.
module tb_trace_monitor;
    import nic8_trace_pkg::*;

    localparam int DW    = 8;
    localparam int CTRLW = 14;
    localparam int DEPTH = 16;
    localparam int SNAPW = 8*DW+CTRLW;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             arm;
    logic [1:0]       mode;
    logic [31:0]      step_limit;
    logic [DW-1:0]    match_pc;
    logic [AW-1:0]    post_count;
    logic             trig_in;
    logic [DW-1:0]    pc, ir, areg, breg, xreg, qreg, abus, dbus;
    logic [CTRLW-1:0] ctrl;
    logic             rd_valid;
    logic             rd_ready;
    logic [SNAPW-1:0] rd_data;
    logic             rd_last;
    logic [1:0]       state;
    logic             triggered;
    logic [31:0]      ticks;

    logic [SNAPW-1:0] exp_q[$];
    logic [SNAPW-1:0] last_data;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_monitor #(.DW(DW), .CTRLW(CTRLW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .mode(mode),
        .step_limit(step_limit), .match_pc(match_pc),
        .post_count(post_count), .trig_in(trig_in),
        .pc(pc), .ir(ir), .areg(areg), .breg(breg), .xreg(xreg),
        .qreg(qreg), .abus(abus), .dbus(dbus), .ctrl(ctrl),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .state(state), .triggered(triggered),
        .ticks(ticks)
    );

    task automatic drive_sample(input logic [7:0] pcv, input logic [7:0] qv,
                                input logic tin);
        pc      = pcv;
        qreg    = qv;
        trig_in = tin;
        ir      = 8'($urandom);
        areg    = 8'($urandom);
        breg    = 8'($urandom);
        xreg    = 8'($urandom);
        abus    = 8'($urandom);
        dbus    = 8'($urandom);
        ctrl    = 14'($urandom);
        exp_q.push_back({pc, ir, areg, breg, xreg, qreg, abus, dbus, ctrl});
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        @(posedge clk); #1;
        trig_in = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [31:0] sl,
                          input logic [7:0] mp, input logic [AW-1:0] pcnt);
        exp_q.delete();
        mode = m; step_limit = sl; match_pc = mp; post_count = pcnt;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        mode = 2'd0; step_limit = 32'hFFFF_FFFF; match_pc = 8'hFF;
        post_count = '0;
        n_checks++;
        if (state !== 2'(ARMED) || ticks !== 32'd0 || triggered !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_entry: state %0d ticks %0d trig %b, need 1 0 0",
                     state, ticks, triggered);
        end
    endtask

    task automatic check_drain_entry(input logic [1:0] st);
        n_checks++;
        if (state !== st) begin
            n_fail++;
            $display("FAIL capture_done: state %0d, need %0d", state, st);
        end
    endtask

    task automatic drain(input int max_n, input int stall_at, output int got);
        logic [SNAPW-1:0] held, e;
        int stall;
        stall = 0; got = 0; held = '0;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && got < max_n; cyc++) begin
            @(posedge clk); #1;
            if (got == stall_at && stall > 0 && stall < 7) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid %b data %h, need 1 %h",
                             rd_valid, rd_data, held);
                end
                stall++;
            end else if (rd_valid) begin
                if (got == stall_at && stall == 0) begin
                    rd_ready = 1'b0;
                    held = rd_data;
                    stall = 1;
                end else begin
                    rd_ready = 1'b1;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_entry: got %h, need none", rd_data);
                        got = max_n;
                    end else begin
                        e = exp_q.pop_front();
                        if (rd_data !== e) begin
                            n_fail++;
                            $display("FAIL entry_%0d: got %h, need %h", got, rd_data, e);
                        end
                        n_checks++;
                        if (rd_last !== (exp_q.size() == 0)) begin
                            n_fail++;
                            $display("FAIL rd_last_%0d: got %b, need %b", got,
                                     rd_last, exp_q.size() == 0);
                        end
                        last_data = rd_data;
                        got++;
                    end
                end
            end
        end
        rd_ready = 1'b1;
        if (got < max_n) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d entries, need %0d", got, max_n);
        end
    endtask

    task automatic check_idle_after;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 2'(IDLE) || rd_valid !== 1'b0 || triggered !== 1'b1) begin
            n_fail++;
            $display("FAIL end_state: state %0d valid %b trig %b, need 0 0 1",
                     state, rd_valid, triggered);
        end
    endtask

    task automatic check_count(input int got, input int need);
        n_checks++;
        if (got !== need) begin
            n_fail++;
            $display("FAIL entry_count: got %0d, need %0d", got, need);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (state !== 2'(IDLE) || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
            triggered !== 1'b0 || ticks !== 32'd0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: st %0d v %b l %b t %b tk %0d d %h, need all 0",
                     state, rd_valid, rd_last, triggered, ticks, rd_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_step;
        int got;
        do_arm(2'd0, 32'd5, 8'h00, 4'd2);
        for (int i = 0; i < 8; i++) drive_sample(8'(i), 8'h00, 1'b0);
        check_drain_entry(2'(DRAIN));
        n_checks++;
        if (ticks !== 32'd8 || triggered !== 1'b1) begin
            n_fail++;
            $display("FAIL step_ticks: ticks %0d trig %b, need 8 1", ticks, triggered);
        end
        drain(8, -1, got);
        check_count(got, 8);
        n_checks++;
        if (last_data[OFF_PC +: 8] !== 8'h07) begin
            n_fail++;
            $display("FAIL step_last_pc: got %h, need 07", last_data[OFF_PC +: 8]);
        end
        check_idle_after();
    endtask

    task automatic test_pcmatch_backpressure;
        int got;
        do_arm(2'd1, 32'd0, 8'h20, 4'd3);
        for (int i = 0; i < 36; i++) drive_sample(8'(i), 8'h00, 1'b0);
        check_drain_entry(2'(DRAIN));
        n_checks++;
        if (exp_q[0][OFF_PC +: 8] !== 8'h14 || exp_q[12][OFF_PC +: 8] !== 8'h20) begin
            n_fail++;
            $display("FAIL pcmatch_model: oldest %h trig %h, need 14 20",
                     exp_q[0][OFF_PC +: 8], exp_q[12][OFF_PC +: 8]);
        end
        drain(16, 5, got);
        check_count(got, 16);
        n_checks++;
        if (last_data[OFF_PC +: 8] !== 8'h23) begin
            n_fail++;
            $display("FAIL pcmatch_last_pc: got %h, need 23", last_data[OFF_PC +: 8]);
        end
        check_idle_after();
    endtask

    task automatic test_qchange;
        int got;
        qreg = 8'h77;
        do_arm(2'd2, 32'd0, 8'h00, 4'd0);
        drive_sample(8'h00, 8'h00, 1'b0);
        n_checks++;
        if (state !== 2'(ARMED)) begin
            n_fail++;
            $display("FAIL qchange_first: state %0d, need 1", state);
        end
        for (int i = 1; i < 10; i++)
            drive_sample(8'(i), (i == 9) ? 8'h2A : 8'h00, 1'b0);
        check_drain_entry(2'(DRAIN));
        drain(10, -1, got);
        check_count(got, 10);
        n_checks++;
        if (last_data[OFF_QREG +: 8] !== 8'h2A) begin
            n_fail++;
            $display("FAIL qchange_last_q: got %h, need 2a", last_data[OFF_QREG +: 8]);
        end
        check_idle_after();
    endtask

    task automatic test_arm_in_drain;
        int got;
        do_arm(2'd3, 32'd0, 8'h00, 4'd1);
        for (int i = 0; i < 6; i++) drive_sample(8'(i + 8'h40), 8'h00, i == 4);
        check_drain_entry(2'(DRAIN));
        drain(3, -1, got);
        check_count(got, 3);
        for (int i = 0; i < 6 && !rd_valid; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fourth_entry: valid %b, need 1", rd_valid);
        end
        // arm and handshake land on the same edge
        do_arm(2'd3, 32'd0, 8'h00, 4'd0);
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_valid: valid %b, need 0", rd_valid);
        end
        for (int i = 0; i < 3; i++) drive_sample(8'(i + 8'h60), 8'h00, i == 2);
        check_drain_entry(2'(DRAIN));
        drain(3, -1, got);
        check_count(got, 3);
        check_idle_after();
    endtask

    task automatic test_async_reset;
        int got;
        do_arm(2'd0, 32'd2, 8'h00, 4'd5);
        for (int i = 0; i < 4; i++) drive_sample(8'(i), 8'h00, 1'b0);
        check_drain_entry(2'(POST));
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'(IDLE) || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
            triggered !== 1'b0 || ticks !== 32'd0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL async_reset: st %0d v %b l %b t %b tk %0d d %h, need all 0",
                     state, rd_valid, rd_last, triggered, ticks, rd_data);
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        do_arm(2'd0, 32'd3, 8'h00, 4'd1);
        for (int i = 0; i < 5; i++) drive_sample(8'(i + 8'h80), 8'h00, 1'b0);
        check_drain_entry(2'(DRAIN));
        drain(5, -1, got);
        check_count(got, 5);
        check_idle_after();
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; mode = 2'd0; step_limit = '0;
        match_pc = '0; post_count = '0; trig_in = 1'b0;
        pc = '0; ir = '0; areg = '0; breg = '0; xreg = '0; qreg = '0;
        abus = '0; dbus = '0; ctrl = '0; rd_ready = 1'b1; last_data = '0;
        test_reset();
        test_step();
        test_pcmatch_backpressure();
        test_qchange();
        test_arm_in_drain();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
